// File: rtl/ymux4_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : ymux4_rr_sched
// Purpose  : Round-robin owner scheduler for a shared 4:1 W-bit mux with a
//            registered valid/ready output stage and per-owner burst limit.
// Option   : YMUX_SCHED_PRIO_EN - fixed-priority arbitration, req[0] preempts.
// Revision : 1.0 - initial release
// ============================================================================
module ymux4_rr_sched #(
  parameter int WIDTH    = 32,
  parameter int MAXBURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_OWN      = 1'b1;
  localparam logic [3:0] C_MAXBURST = 4'(MAXBURST);

  logic [0:0]       r_state;
  logic [0:0]       w_next_state;
  logic [1:0]       r_sel;
  logic [3:0]       r_burst_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_src;

  logic             w_slot_free;
  logic             w_accept;
  logic             w_burst_hit;
  logic             w_prio_hit;
  logic             w_release;
  logic [1:0]       w_choice;
  logic [WIDTH-1:0] w_mux_data;

  assign w_slot_free = ~r_out_valid | out_ready;
  assign w_burst_hit = (r_burst_cnt + 4'd1) == C_MAXBURST;
  assign w_release   = (r_state == S_OWN) &
                       (~req[r_sel] | (w_accept & (w_burst_hit | w_prio_hit)));

`ifdef YMUX_SCHED_PRIO_EN
  logic r_req0_q;
  logic r_prio_pend;
  logic w_prio_rise;

  assign w_prio_rise = req[0] & ~r_req0_q;
  // A rising req[0] behaves like a burst-limit hit for any other owner.
  assign w_prio_hit  = (r_sel != 2'd0) & (r_prio_pend | w_prio_rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req0_q    <= 1'b0;
      r_prio_pend <= 1'b0;
    end else begin
      r_req0_q <= req[0];
      if (r_state != S_OWN || w_release) begin
        r_prio_pend <= 1'b0;
      end else if (w_prio_rise && r_sel != 2'd0) begin
        r_prio_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    w_choice = 2'd0;
    if (req[0]) begin
      w_choice = 2'd0;
    end else if (req[1]) begin
      w_choice = 2'd1;
    end else if (req[2]) begin
      w_choice = 2'd2;
    end else if (req[3]) begin
      w_choice = 2'd3;
    end
  end
`else
  logic [1:0] r_last;
  logic [1:0] w_idx;
  logic       w_found;

  assign w_prio_hit = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 2'd3;
    end else if (w_release) begin
      r_last <= r_sel;
    end
  end

  // Cyclic search starting just after the previous owner.
  always_comb begin
    w_choice = r_last;
    w_found  = 1'b0;
    w_idx    = r_last;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_choice = w_idx;
        w_found  = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    case (r_sel)
      2'd0:    w_mux_data = d0;
      2'd1:    w_mux_data = d1;
      2'd2:    w_mux_data = d2;
      default: w_mux_data = d3;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (|req) w_next_state = S_OWN;
      S_OWN:   if (w_release) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic: grant only the owner, only when its word can be captured.
  always_comb begin
    w_accept = 1'b0;
    gnt      = 4'b0000;
    if (r_state == S_OWN && req[r_sel] && w_slot_free) begin
      w_accept   = 1'b1;
      gnt[r_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= 2'd0;
      r_burst_cnt <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_sel       <= w_choice;
            r_burst_cnt <= 4'd0;
          end
        end
        S_OWN: begin
          if (w_release) begin
            r_burst_cnt <= 4'd0;
          end else if (w_accept) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
          end
        end
        default: r_burst_cnt <= 4'd0;
      endcase
    end
  end

  // Output stage: a new capture replaces a word consumed in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 2'd0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_src   <= r_sel;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_ymux4_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ymux4_rr_sched
// Purpose  : Directed scoreboard bench for ymux4_rr_sched (YMUX_SCHED_PRIO_EN
//            selects the priority-mode vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ymux4_rr_sched;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
  } cyc_t;

  typedef struct packed {
    logic [1:0]       src;
    logic [WIDTH-1:0] data;
  } word_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;

  cyc_t  cyc_q[$];
  word_t word_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cnt   = 0;

  ymux4_rr_sched #(.WIDTH(WIDTH), .MAXBURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: per-cycle expectations and consumed output words.
  always @(negedge clk) begin
    cyc_t  e;
    word_t w;
    if (rst_n && cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check("gnt", 32'(gnt), 32'(e.g));
      check("sel", 32'(sel), 32'(e.s));
      check("out_valid", 32'(out_valid), 32'(e.v));
    end
    if (rst_n && out_valid && out_ready) begin
      if (word_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word at %0t: got src=%0d data=%h expected none", $time, out_src, out_data);
      end else begin
        w = word_q.pop_front();
        check("out_data", out_data, w.data);
        check("out_src", 32'(out_src), 32'(w.src));
      end
    end
  end

  // One clock of stimulus with its hand-computed expected gnt/sel/out_valid.
  task automatic cyc(input logic [3:0] r, input logic rdy, input logic [3:0] eg,
                     input logic [1:0] es, input logic eov);
    word_t w;
    cnt++;
    req       = r;
    out_ready = rdy;
    d0 = 32'hA5A5_0000 + 32'(cnt);
    d1 = 32'hB1B1_0000 + 32'(cnt);
    d2 = 32'hC2C2_0000 + 32'(cnt);
    d3 = 32'hD3D3_0000 + 32'(cnt);
    cyc_q.push_back('{g: eg, s: es, v: eov});
    if (eg != 4'b0000) begin
      case (eg)
        4'b0001: begin w.src = 2'd0; w.data = d0; end
        4'b0010: begin w.src = 2'd1; w.data = d1; end
        4'b0100: begin w.src = 2'd2; w.data = d2; end
        default: begin w.src = 2'd3; w.data = d3; end
      endcase
      word_q.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_src"}, 32'(out_src), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] own;
    rst_n = 1'b0; req = 4'b0; out_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    @(posedge clk); #1;
    reset_checks("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifndef YMUX_SCHED_PRIO_EN
    // Single requester: two bursts of 4 with one bubble.
    cyc(4'b0001, 1, 4'b0000, 2'd0, 0);
    for (int j = 0; j < 4; j++) cyc(4'b0001, 1, 4'b0001, 2'd0, j != 0);
    cyc(4'b0001, 1, 4'b0000, 2'd0, 1);
    for (int j = 0; j < 4; j++) cyc(4'b0001, 1, 4'b0001, 2'd0, j != 0);
    cyc(4'b0000, 1, 4'b0000, 2'd0, 1);

    // All requesting: round-robin from the last owner (0).
    cyc(4'b1111, 1, 4'b0000, 2'd0, 0);
    for (int k = 0; k < 4; k++) begin
      own = 2'(k + 1);
      for (int j = 0; j < 4; j++) cyc(4'b1111, 1, 4'(1 << own), own, j != 0);
      cyc((k == 3) ? 4'b0000 : 4'b1111, 1, 4'b0000, own, 1);
    end
    cyc(4'b0000, 1, 4'b0000, 2'd0, 0);

    // Owner 2 stalled by out_ready=0 for 3 cycles.
    cyc(4'b0100, 1, 4'b0000, 2'd0, 0);
    cyc(4'b0100, 1, 4'b0100, 2'd2, 0);
    for (int j = 0; j < 3; j++) cyc(4'b0100, 0, 4'b0000, 2'd2, 1);
    for (int j = 0; j < 3; j++) cyc(4'b0100, 1, 4'b0100, 2'd2, 1);
    cyc(4'b0000, 1, 4'b0000, 2'd2, 1);

    // Short burst then drop; next search starts at 3.
    cyc(4'b0100, 1, 4'b0000, 2'd2, 0);
    cyc(4'b0100, 1, 4'b0100, 2'd2, 0);
    cyc(4'b0100, 1, 4'b0100, 2'd2, 1);
    cyc(4'b0000, 1, 4'b0000, 2'd2, 1);
    cyc(4'b1001, 1, 4'b0000, 2'd2, 0);
    cyc(4'b1001, 1, 4'b1000, 2'd3, 0);
    cyc(4'b0000, 1, 4'b0000, 2'd3, 1);
    cyc(4'b0000, 1, 4'b0000, 2'd3, 0);

    // Asynchronous reset in the middle of a burst from source 1.
    cyc(4'b0010, 1, 4'b0000, 2'd3, 0);
    cyc(4'b0010, 1, 4'b0010, 2'd1, 0);
    cyc(4'b0010, 1, 4'b0010, 2'd1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    word_q.delete();
    reset_checks("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(4'b1000, 1, 4'b0000, 2'd0, 0);
    cyc(4'b1000, 1, 4'b1000, 2'd3, 0);
    cyc(4'b0000, 1, 4'b0000, 2'd3, 1);
    cyc(4'b0000, 1, 4'b0000, 2'd3, 0);
`else
    // Owner 3 preempted by a rising req[0] at its next accept.
    cyc(4'b1000, 1, 4'b0000, 2'd0, 0);
    cyc(4'b1000, 1, 4'b1000, 2'd3, 0);
    cyc(4'b1001, 1, 4'b1000, 2'd3, 1);
    cyc(4'b1001, 1, 4'b0000, 2'd3, 1);
    cyc(4'b1001, 1, 4'b0001, 2'd0, 0);
    cyc(4'b0000, 1, 4'b0000, 2'd0, 1);
    cyc(4'b0000, 1, 4'b0000, 2'd0, 0);
`endif

    check("words_left", 32'(word_q.size()), 32'd0);
    check("cycles_left", 32'(cyc_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
